// File: rtl/jtpinpon_rom_arb_if.sv
// Bundle for the three ROM requesters and the shared SDRAM read port.
// The slave modport is the arbiter; the master modport is the requesters plus the SDRAM.
interface jtpinpon_rom_arb_if #(
    parameter int unsigned AW = 22
);
    logic          main_cs;
    logic [AW-1:0] main_addr;
    logic [15:0]   main_data;
    logic          main_ok;
    logic          scr_cs;
    logic [AW-1:0] scr_addr;
    logic [15:0]   scr_data;
    logic          scr_ok;
    logic          obj_cs;
    logic [AW-1:0] obj_addr;
    logic [15:0]   obj_data;
    logic          obj_ok;
    logic [AW-1:0] sdram_addr;
    logic          sdram_rd;
    logic          sdram_ack;
    logic          sdram_rdy;
    logic [15:0]   sdram_din;

    modport slave (
        input  main_cs, main_addr, scr_cs, scr_addr, obj_cs, obj_addr,
        input  sdram_ack, sdram_rdy, sdram_din,
        output main_data, main_ok, scr_data, scr_ok, obj_data, obj_ok,
        output sdram_addr, sdram_rd
    );

    modport master (
        output main_cs, main_addr, scr_cs, scr_addr, obj_cs, obj_addr,
        output sdram_ack, sdram_rdy, sdram_din,
        input  main_data, main_ok, scr_data, scr_ok, obj_data, obj_ok,
        input  sdram_addr, sdram_rd
    );
endinterface

// File: rtl/jtpinpon_rom_arb.sv
// Three-way ROM arbiter onto one SDRAM read port, with a one-word cache per requester.
// Main has fixed priority; scroll and object alternate when both are waiting.
module jtpinpon_rom_arb #(
    parameter int unsigned   AW          = 22,
    parameter logic [AW-1:0] MAIN_OFFSET = '0,
    parameter logic [AW-1:0] SCR_OFFSET  = '0,
    parameter logic [AW-1:0] OBJ_OFFSET  = '0
) (
    input logic               clk,
    input logic               rst,
    jtpinpon_rom_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;
    localparam int NREQ = 3;

    state_t                    state_q, state_d;
    logic [1:0]                gnt_q, gnt_d;
    logic [AW-1:0]             lat_addr_q, lat_addr_d;
    logic [AW-1:0]             sdram_addr_q, sdram_addr_d;
    logic                      sdram_rd_q, sdram_rd_d;
    logic                      rr_obj_q, rr_obj_d;
    logic [NREQ-1:0][AW-1:0]   tag_q, tag_d;
    logic [NREQ-1:0][15:0]     data_q, data_d;
    logic [NREQ-1:0]           valid_q, valid_d;

    logic [NREQ-1:0]           cs, ok, pend;
    logic [NREQ-1:0][AW-1:0]   addr, offs;
    logic [1:0]                sel;
    logic                      store;

    // Index 0 = main, 1 = scroll, 2 = object
    assign cs   = {bus.obj_cs, bus.scr_cs, bus.main_cs};
    assign addr = {bus.obj_addr, bus.scr_addr, bus.main_addr};
    assign offs = {OBJ_OFFSET, SCR_OFFSET, MAIN_OFFSET};

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            ok[i] = cs[i] & valid_q[i] & (addr[i] == tag_q[i]);
    end
    assign pend = cs & ~ok;

    assign bus.main_ok    = ok[0];
    assign bus.scr_ok     = ok[1];
    assign bus.obj_ok     = ok[2];
    assign bus.main_data  = data_q[0];
    assign bus.scr_data   = data_q[1];
    assign bus.obj_data   = data_q[2];
    assign bus.sdram_addr = sdram_addr_q;
    assign bus.sdram_rd   = sdram_rd_q;

    // rr_obj_q set means object wins a tie with scroll
    always_comb begin
        sel = 2'd1;
        if (pend[0])                 sel = 2'd0;
        else if (pend[1] && pend[2]) sel = rr_obj_q ? 2'd2 : 2'd1;
        else if (pend[2])            sel = 2'd2;
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        lat_addr_d   = lat_addr_q;
        sdram_addr_d = sdram_addr_q;
        sdram_rd_d   = sdram_rd_q;
        rr_obj_d     = rr_obj_q;
        tag_d        = tag_q;
        data_d       = data_q;
        valid_d      = valid_q;
        store        = 1'b0;
        case (state_q)
            IDLE: if (|pend) begin
                gnt_d        = sel;
                lat_addr_d   = addr[sel];
                sdram_addr_d = addr[sel] + offs[sel];
                sdram_rd_d   = 1'b1;
                state_d      = WAIT_ACK;
                if (sel != 2'd0) rr_obj_d = (sel == 2'd1);
            end
            WAIT_ACK: if (bus.sdram_ack) begin
                sdram_rd_d = 1'b0;
                if (bus.sdram_rdy) begin
                    store   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: if (bus.sdram_rdy) begin
                store   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The fill uses the address latched at grant, not whatever the requester shows now
        for (int i = 0; i < NREQ; i++) begin
            if (store && gnt_q == 2'(i)) begin
                tag_d[i]   = lat_addr_q;
                data_d[i]  = bus.sdram_din;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            lat_addr_q   <= '0;
            sdram_addr_q <= '0;
            sdram_rd_q   <= 1'b0;
            rr_obj_q     <= 1'b1;
            tag_q        <= '0;
            data_q       <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            lat_addr_q   <= lat_addr_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_rd_q   <= sdram_rd_d;
            rr_obj_q     <= rr_obj_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
        end
    end
endmodule

// File: tb/tb_jtpinpon_rom_arb.sv
// Bench for jtpinpon_rom_arb: fixed vector table, corner sequences, then random
// traffic against a cache-and-last-served reference model.
module tb_jtpinpon_rom_arb;
    localparam int unsigned AW = 22;
    localparam logic [AW-1:0] MOFF = 22'h008000;
    localparam logic [AW-1:0] SOFF = 22'h001000;
    localparam logic [AW-1:0] OOFF = 22'h3FFFF0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtpinpon_rom_arb_if #(.AW(AW)) bus();

    jtpinpon_rom_arb #(
        .AW(AW), .MAIN_OFFSET(MOFF), .SCR_OFFSET(SOFF), .OBJ_OFFSET(OOFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          mcs;
        logic [AW-1:0] maddr;
        logic          scs;
        logic [AW-1:0] saddr;
        logic          ocs;
        logic [AW-1:0] oaddr;
        logic [15:0]   din;
        int            ack_dly;
        int            rdy_dly;
        logic          exp_rd;
        logic [AW-1:0] exp_sa;
        int            exp_gnt;
        logic [2:0]    pre_ok;
        logic [2:0]    post_ok;
    } vec_t;
    vec_t vt[7];

    logic          rc[3];
    logic [AW-1:0] ra[3];
    logic [AW-1:0] m_tag[3];
    logic [15:0]   m_dat[3];
    bit            m_val[3];
    int            last_so;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] okv();
        return {bus.obj_ok, bus.scr_ok, bus.main_ok};
    endfunction

    function automatic logic [15:0] dat(input int g);
        case (g)
            0:       return bus.main_data;
            1:       return bus.scr_data;
            default: return bus.obj_data;
        endcase
    endfunction

    function automatic logic [AW-1:0] offset_of(input int g);
        case (g)
            0:       return MOFF;
            1:       return SOFF;
            default: return OOFF;
        endcase
    endfunction

    function automatic logic [AW-1:0] sd_addr(input int g, input logic [AW-1:0] a);
        longint s;
        s = (longint'(a) + longint'(offset_of(g))) % (longint'(1) << AW);
        return AW'(s);
    endfunction

    task automatic drive();
        bus.main_cs = rc[0]; bus.main_addr = ra[0];
        bus.scr_cs  = rc[1]; bus.scr_addr  = ra[1];
        bus.obj_cs  = rc[2]; bus.obj_addr  = ra[2];
    endtask

    // SDRAM side of one transaction, starting in the first WAIT_ACK cycle
    task automatic respond(input int ack_dly, input int rdy_dly, input logic [15:0] d, input bit both);
        for (int k = 0; k < ack_dly; k++) begin
            tick();
            chk("rd_hold", bus.sdram_rd, 1'b1);
        end
        bus.sdram_ack = 1'b1;
        bus.sdram_rdy = both;
        bus.sdram_din = d;
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        if (!both) begin
            chk("rd_drop", bus.sdram_rd, 1'b0);
            for (int k = 0; k < rdy_dly; k++) tick();
            bus.sdram_rdy = 1'b1;
            bus.sdram_din = d;
            tick();
            bus.sdram_rdy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin rc[i] = 1'b0; ra[i] = '0; end
        drive();
        bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0; bus.sdram_din = '0;
        tick(); tick();
        chk("rst_rd", bus.sdram_rd, 1'b0);
        chk("rst_addr", bus.sdram_addr, '0);
        chk("rst_ok", okv(), 3'b000);
        chk("rst_data", {bus.main_data, bus.scr_data, bus.obj_data}, '0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin m_tag[i] = '0; m_dat[i] = '0; m_val[i] = 1'b0; end
        last_so = 1;
    endtask

    initial begin
        vt[0] = '{1'b1, 22'h100, 1'b0, 22'h0,  1'b0, 22'h0,  16'hBEEF, 2, 3, 1'b1, 22'h008100, 0, 3'b000, 3'b001};
        vt[1] = '{1'b1, 22'h100, 1'b0, 22'h0,  1'b0, 22'h0,  16'h0000, 0, 0, 1'b0, 22'h0,      3, 3'b001, 3'b001};
        vt[2] = '{1'b1, 22'h200, 1'b1, 22'h10, 1'b1, 22'h20, 16'h1111, 0, 0, 1'b1, 22'h008200, 0, 3'b000, 3'b001};
        vt[3] = '{1'b1, 22'h200, 1'b1, 22'h10, 1'b1, 22'h20, 16'h2222, 1, 1, 1'b1, 22'h000010, 2, 3'b001, 3'b101};
        vt[4] = '{1'b1, 22'h200, 1'b1, 22'h10, 1'b1, 22'h20, 16'h3333, 0, 2, 1'b1, 22'h001010, 1, 3'b101, 3'b111};
        vt[5] = '{1'b0, 22'h0,   1'b1, 22'h11, 1'b1, 22'h21, 16'h4444, 1, 0, 1'b1, 22'h000011, 2, 3'b000, 3'b100};
        vt[6] = '{1'b0, 22'h0,   1'b1, 22'h11, 1'b1, 22'h21, 16'h5555, 0, 0, 1'b1, 22'h001011, 1, 3'b100, 3'b110};

        do_reset();

        foreach (vt[i]) begin
            rc[0] = vt[i].mcs; ra[0] = vt[i].maddr;
            rc[1] = vt[i].scs; ra[1] = vt[i].saddr;
            rc[2] = vt[i].ocs; ra[2] = vt[i].oaddr;
            drive();
            #1;
            chk($sformatf("vec%0d_pre_ok", i), okv(), vt[i].pre_ok);
            tick();
            chk($sformatf("vec%0d_rd", i), bus.sdram_rd, vt[i].exp_rd);
            if (vt[i].exp_rd) begin
                chk($sformatf("vec%0d_addr", i), bus.sdram_addr, vt[i].exp_sa);
                respond(vt[i].ack_dly, vt[i].rdy_dly, vt[i].din, 1'b0);
                chk($sformatf("vec%0d_data", i), dat(vt[i].exp_gnt), vt[i].din);
            end
            chk($sformatf("vec%0d_post_ok", i), okv(), vt[i].post_ok);
        end

        // Scroll address moves while the read is in flight; then ack+rdy in one cycle
        rc[0] = 1'b0; rc[2] = 1'b0; rc[1] = 1'b1; ra[1] = 22'h40;
        drive();
        tick();
        chk("mid_rd", bus.sdram_rd, 1'b1);
        chk("mid_addr", bus.sdram_addr, 22'h001040);
        bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
        ra[1] = 22'h41; drive();
        tick();
        chk("mid_rd_low", bus.sdram_rd, 1'b0);
        bus.sdram_rdy = 1'b1; bus.sdram_din = 16'hAAAA; tick(); bus.sdram_rdy = 1'b0;
        chk("mid_ok_new", bus.scr_ok, 1'b0);
        chk("mid_data", bus.scr_data, 16'hAAAA);
        bus.scr_addr = 22'h40; #1;
        chk("mid_tag_old", bus.scr_ok, 1'b1);
        bus.scr_addr = 22'h41; #1;
        chk("mid_idle_gap", bus.sdram_rd, 1'b0);
        tick();
        chk("mid_rereq", bus.sdram_rd, 1'b1);
        chk("mid_rereq_addr", bus.sdram_addr, 22'h001041);
        respond(0, 0, 16'hBBBB, 1'b1);
        chk("both_rd", bus.sdram_rd, 1'b0);
        chk("both_ok", bus.scr_ok, 1'b1);
        chk("both_data", bus.scr_data, 16'hBBBB);
        tick();
        chk("both_idle", bus.sdram_rd, 1'b0);

        // Reset while waiting for data; the late rdy must not fill anything
        rc[1] = 1'b0; rc[0] = 1'b1; ra[0] = 22'h300; rc[2] = 1'b1; ra[2] = 22'h21;
        drive();
        tick();
        chk("rst_mid_rd", bus.sdram_rd, 1'b1);
        chk("rst_mid_addr", bus.sdram_addr, 22'h008300);
        bus.sdram_ack = 1'b1; tick(); bus.sdram_ack = 1'b0;
        chk("rst_mid_obj_ok", bus.obj_ok, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_mid_rd0", bus.sdram_rd, 1'b0);
        chk("rst_mid_addr0", bus.sdram_addr, '0);
        chk("rst_mid_ok", okv(), 3'b000);
        chk("rst_mid_odata", bus.obj_data, 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) rc[i] = 1'b0;
        drive();
        bus.sdram_rdy = 1'b1; bus.sdram_din = 16'hCCCC; tick(); bus.sdram_rdy = 1'b0;
        chk("late_rdy_data", {bus.main_data, bus.scr_data, bus.obj_data}, '0);
        chk("late_rdy_rd", bus.sdram_rd, 1'b0);
        rc[0] = 1'b1; drive(); #1;
        chk("late_rdy_ok", bus.main_ok, 1'b0);
        tick();
        chk("late_rdy_rereq", bus.sdram_rd, 1'b1);

        // Random traffic against the reference model
        do_reset();
        for (int it = 0; it < 300; it++) begin
            logic [2:0] pend;
            logic [2:0] eok;
            int g;
            logic [AW-1:0] lat;
            logic [15:0] d;
            for (int i = 0; i < 3; i++) begin
                rc[i] = ($urandom % 4) != 0;
                ra[i] = AW'($urandom % 4);
            end
            drive();
            #1;
            for (int i = 0; i < 3; i++) eok[i] = rc[i] && m_val[i] && (ra[i] == m_tag[i]);
            chk("rnd_ok", okv(), eok);
            chk("rnd_data", {bus.obj_data, bus.scr_data, bus.main_data}, {m_dat[2], m_dat[1], m_dat[0]});
            for (int i = 0; i < 3; i++) pend[i] = rc[i] && !eok[i];
            if (pend == 3'b000) begin
                bus.sdram_rdy = 1'($urandom % 2);
                bus.sdram_din = 16'($urandom);
                tick();
                bus.sdram_rdy = 1'b0;
                chk("rnd_no_rd", bus.sdram_rd, 1'b0);
                continue;
            end
            if (pend[0])                 g = 0;
            else if (pend[1] && pend[2]) g = (last_so == 1) ? 2 : 1;
            else if (pend[1])            g = 1;
            else                         g = 2;
            lat = ra[g];
            tick();
            chk("rnd_rd", bus.sdram_rd, 1'b1);
            chk("rnd_addr", bus.sdram_addr, sd_addr(g, lat));
            if ($urandom % 4 == 0) begin
                ra[g] = AW'($urandom % 4);
                rc[g] = 1'($urandom % 2);
                drive();
            end
            d = 16'($urandom);
            respond(int'($urandom % 3), int'($urandom % 4), d, ($urandom % 4) == 0);
            m_tag[g] = lat;
            m_dat[g] = d;
            m_val[g] = 1'b1;
            if (g != 0) last_so = g;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jtpinpon_rom_arb.md
JTPINPON_ROM_ARB -- requirements
Module: jtpinpon_rom_arb

Interface
REQ-001 Parameter AW, default 22: word-address width of every requester and the SDRAM port.
REQ-002 Parameter MAIN_OFFSET, default 0: AW-bit word offset added to main requests.
REQ-003 Parameter SCR_OFFSET, default 0: AW-bit word offset added to scroll requests.
REQ-004 Parameter OBJ_OFFSET, default 0: AW-bit word offset added to object requests.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 main_cs  in  1; main_addr  in  AW; main_data  out  16; main_ok  out  1.  CPU ROM requester.
REQ-008 scr_cs  in  1; scr_addr  in  AW; scr_data  out  16; scr_ok  out  1.  Scroll ROM requester.
REQ-009 obj_cs  in  1; obj_addr  in  AW; obj_data  out  16; obj_ok  out  1.  Object ROM requester.
REQ-010 sdram_addr  out  AW: word address incl. offset; sdram_rd  out  1: read request.
REQ-011 sdram_ack  in  1: request accepted; sdram_rdy  in  1: read data valid; sdram_din  in  16: read data.

Function
REQ-012 Each requester SHALL own a one-entry cache: tag (AW), data (16), valid (1).
REQ-013 xx_ok SHALL be combinational: xx_cs & valid & (xx_addr == tag); xx_data SHALL equal cached data at all times.
REQ-014 A requester is pending when xx_cs=1 and its ok=0.
REQ-015 FSM states IDLE, WAIT_ACK, WAIT_RDY; one SDRAM transaction outstanding at most.
REQ-016 IDLE: if any pending, grant one, latch its index and xx_addr, drive sdram_addr = addr + offset (mod 2^AW), assert sdram_rd, go WAIT_ACK next cycle.
REQ-017 Grant priority: main highest; scr/obj tie resolved round-robin, the one not granted last among scr/obj wins; round-robin pointer reset to favour obj.
REQ-018 WAIT_ACK: hold sdram_rd=1 and sdram_addr stable until sdram_ack=1; on ack drop sdram_rd next cycle, go WAIT_RDY.
REQ-019 sdram_ack and sdram_rdy both high in the same WAIT_ACK cycle: treat as completed, store data, go IDLE.
REQ-020 WAIT_RDY: on sdram_rdy=1 store sdram_din into the granted cache, tag = latched address, valid=1, go IDLE.
REQ-021 Completion latency: data visible and ok high (if address unchanged) the cycle after sdram_rdy.
REQ-022 IDLE→grant SHALL take one cycle minimum; back-to-back requests separated by exactly one IDLE cycle.
REQ-023 Requester dropping cs or changing address mid-transaction: transaction completes, cache loads the latched address; no abort, ok stays low for the new address, new request issued afterwards.
REQ-024 Writes to the granted requester's cache SHALL not alter other caches.
REQ-025 sdram_rdy outside WAIT_ACK/WAIT_RDY SHALL be ignored.
REQ-026 Address wrap: offset addition truncated to AW bits, no carry out.

Reset
REQ-027 rst=1 at any clock, including mid-transaction: state IDLE, sdram_rd=0, sdram_addr=0, all valid=0, all tags and data=0, round-robin favours obj.
REQ-028 During and after reset all xx_ok=0 and xx_data=0 until the first fill.
REQ-029 A transaction in flight at reset is abandoned; later sdram_rdy for it is ignored.

Verification
REQ-030 main_cs=1, main_addr=0x100, MAIN_OFFSET=0x8000; ack 2 cycles later, rdy with 0xBEEF 3 cycles after that -> sdram_addr=0x8100, main_data=0xBEEF, main_ok=1 the cycle after rdy.
REQ-031 main, scr, obj all pending from IDLE -> grants main, obj, scr, in that order; then scr, obj pending again -> obj granted (scr not favoured over last-served order reversal checked: obj, then scr).
REQ-032 Repeat main_addr=0x100 after fill -> main_ok=1 same cycle, no sdram_rd pulse.
REQ-033 scr_addr changes 0x10→0x11 while in WAIT_RDY -> cache tag 0x10, scr_ok=0, second request for 0x11 issued after one IDLE cycle.
REQ-034 sdram_ack and sdram_rdy high together -> single-cycle completion, FSM back in IDLE next cycle, sdram_rd low.
REQ-035 rst asserted in WAIT_RDY, then sdram_rdy pulsed -> all ok=0, no cache written, sdram_rd=0.
